// File: rtl/vga_object_compositor.sv
// Object compositor: double-buffered object table, per-slot hit test, priority palette lookup.
// Optional overlap statistics port enabled by defining VGA_COMP_OVERLAP_CNT_EN.
module vga_object_compositor #(
    parameter int NUM_OBJ = 16,
    parameter int COORD_W = 10,
    parameter int COLOR_W = 10,
    parameter int TYPE_W  = 10
) (
    input  logic                       iVGA_CLK,
    input  logic                       iRST,
    input  logic [COORD_W-1:0]         iVGA_X,
    input  logic [COORD_W-1:0]         iVGA_Y,
    input  logic                       iFrame_Start,
    input  logic                       iWr_Valid,
    output logic                       oWr_Ready,
    input  logic [$clog2(NUM_OBJ)-1:0] iWr_Idx,
    input  logic [COORD_W-1:0]         iWr_X,
    input  logic [COORD_W-1:0]         iWr_Y,
    input  logic [COORD_W-1:0]         iWr_W,
    input  logic [COORD_W-1:0]         iWr_H,
    input  logic [TYPE_W-1:0]          iWr_Type,
    input  logic                       iWr_En,
    output logic [COLOR_W-1:0]         oRed,
    output logic [COLOR_W-1:0]         oGreen,
    output logic [COLOR_W-1:0]         oBlue,
    output logic                       oHit_Valid,
    output logic [$clog2(NUM_OBJ)-1:0] oHit_Idx
`ifdef VGA_COMP_OVERLAP_CNT_EN
    ,
    output logic [19:0]                oOverlap_Cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_OBJ);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [TYPE_W-1:0]  kind;
        logic               en;
    } slot_t;

    // Extents are formed one bit wider so objects running off the right/bottom edge clip.
    function automatic logic slot_hit(input slot_t s, input logic [COORD_W-1:0] px,
                                      input logic [COORD_W-1:0] py);
        logic [COORD_W:0] x_end;
        logic [COORD_W:0] y_end;
        x_end = {1'b0, s.x} + {1'b0, s.w};
        y_end = {1'b0, s.y} + {1'b0, s.h};
        return s.en && (s.w != '0) && (s.h != '0) &&
               (px >= s.x) && ({1'b0, px} < x_end) &&
               (py >= s.y) && ({1'b0, py} < y_end);
    endfunction

    function automatic logic [3*COLOR_W-1:0] palette(input logic [TYPE_W-1:0] kind);
        case (kind)
            TYPE_W'(101): return {COLOR_W'(0),   COLOR_W'(255), COLOR_W'(0)};
            TYPE_W'(102): return {COLOR_W'(255), COLOR_W'(255), COLOR_W'(0)};
            TYPE_W'(201): return {COLOR_W'(153), COLOR_W'(0),   COLOR_W'(0)};
            TYPE_W'(202): return {COLOR_W'(0),   COLOR_W'(255), COLOR_W'(255)};
            TYPE_W'(302): return {COLOR_W'(204), COLOR_W'(0),   COLOR_W'(204)};
            default:      return {COLOR_W'(255), COLOR_W'(255), COLOR_W'(255)};
        endcase
    endfunction

    slot_t shadow_tbl [NUM_OBJ];
    slot_t active_tbl [NUM_OBJ];
    logic  seen_rst;
    logic  wr_ready;

    // Ready stays low until the block has been reset once.
    assign wr_ready  = seen_rst && !iRST && !iFrame_Start;
    assign oWr_Ready = wr_ready;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            seen_rst <= 1'b1;
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                shadow_tbl[i].en <= 1'b0;
                active_tbl[i].en <= 1'b0;
            end
        end else begin
            if (wr_ready && iWr_Valid && (int'(iWr_Idx) < NUM_OBJ)) begin
                shadow_tbl[iWr_Idx] <= {iWr_X, iWr_Y, iWr_W, iWr_H, iWr_Type, iWr_En};
            end
            if (iFrame_Start) begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    active_tbl[i] <= shadow_tbl[i];
                end
            end
        end
    end

    logic [NUM_OBJ-1:0] hit_now;

    always_comb begin
        hit_now = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            hit_now[i] = slot_hit(active_tbl[i], iVGA_X, iVGA_Y);
        end
    end

    // Stage 1: hit vector plus the types it refers to, so a table swap cannot skew stage 2.
    logic [NUM_OBJ-1:0] hit_p1;
    logic [TYPE_W-1:0]  kind_p1 [NUM_OBJ];

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            hit_p1 <= '0;
            for (int i = 0; i < NUM_OBJ; i++) kind_p1[i] <= '0;
        end else begin
            hit_p1 <= hit_now;
            for (int i = 0; i < NUM_OBJ; i++) kind_p1[i] <= active_tbl[i].kind;
        end
    end

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [TYPE_W-1:0] win_kind;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_kind  = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit_p1[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_kind  = kind_p1[i];
            end
        end
    end

    // Stage 2: priority select and palette lookup.
    logic [3*COLOR_W-1:0] rgb_p2;
    logic                 vld_p2;
    logic [IDX_W-1:0]     idx_p2;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            rgb_p2 <= '0;
            vld_p2 <= 1'b0;
            idx_p2 <= '0;
        end else begin
            rgb_p2 <= win_found ? palette(win_kind) : '0;
            vld_p2 <= win_found;
            idx_p2 <= win_idx;
        end
    end

    assign {oRed, oGreen, oBlue} = rgb_p2;
    assign oHit_Valid            = vld_p2;
    assign oHit_Idx              = idx_p2;

`ifdef VGA_COMP_OVERLAP_CNT_EN
    function automatic logic [19:0] sat_inc(input logic [19:0] cnt, input logic inc);
        return (inc && (cnt != '1)) ? cnt + 20'd1 : cnt;
    endfunction

    logic        multi_hit;
    logic [19:0] overlap_run;
    logic [19:0] overlap_q;

    assign multi_hit = (hit_now & (hit_now - NUM_OBJ'(1))) != '0;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            overlap_run <= '0;
            overlap_q   <= '0;
        end else if (iFrame_Start) begin
            overlap_q   <= sat_inc(overlap_run, multi_hit);
            overlap_run <= '0;
        end else begin
            overlap_run <= sat_inc(overlap_run, multi_hit);
        end
    end

    assign oOverlap_Cnt = overlap_q;
`else
    // No overlap statistics in this build.
`endif

endmodule

// File: tb/tb_vga_object_compositor.sv
// Bench for vga_object_compositor: directed scenarios then random traffic, checked cycle by cycle
// against a slot-list reference model.
module tb_vga_object_compositor;

    logic       clk = 1'b0;
    logic       iRST, iFrame_Start, iWr_Valid, iWr_En;
    logic [9:0] iVGA_X, iVGA_Y, iWr_X, iWr_Y, iWr_W, iWr_H, iWr_Type;
    logic [3:0] iWr_Idx;
    logic       oWr_Ready, oHit_Valid;
    logic [9:0] oRed, oGreen, oBlue;
    logic [3:0] oHit_Idx;

    always #5 clk = ~clk;

    vga_object_compositor dut (
        .iVGA_CLK(clk), .iRST(iRST), .iVGA_X(iVGA_X), .iVGA_Y(iVGA_Y),
        .iFrame_Start(iFrame_Start), .iWr_Valid(iWr_Valid), .oWr_Ready(oWr_Ready),
        .iWr_Idx(iWr_Idx), .iWr_X(iWr_X), .iWr_Y(iWr_Y), .iWr_W(iWr_W), .iWr_H(iWr_H),
        .iWr_Type(iWr_Type), .iWr_En(iWr_En), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .oHit_Valid(oHit_Valid), .oHit_Idx(oHit_Idx)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: shadow/active slot lists and the two-deep result pipeline.
    int sx[16], sy[16], sw[16], sh[16], st[16];
    bit se[16];
    int ax[16], ay[16], aw[16], ah[16], at[16];
    bit ae[16];
    int p1_r = 0, p1_g = 0, p1_b = 0, p1_v = 0, p1_i = 0;
    int o_r = 0, o_g = 0, o_b = 0, o_v = 0, o_i = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_pixel(input int x, input int y, output int r, output int g,
                                        output int b, output int v, output int idx);
        r = 0; g = 0; b = 0; v = 0; idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (v == 0 && ae[i] && x >= ax[i] && x < ax[i] + aw[i] &&
                y >= ay[i] && y < ay[i] + ah[i]) begin
                v = 1;
                idx = i;
                case (at[i])
                    101: begin r = 0;   g = 255; b = 0;   end
                    102: begin r = 255; g = 255; b = 0;   end
                    201: begin r = 153; g = 0;   b = 0;   end
                    202: begin r = 0;   g = 255; b = 255; end
                    302: begin r = 204; g = 0;   b = 204; end
                    default: begin r = 255; g = 255; b = 255; end
                endcase
            end
        end
    endfunction

    // One clock cycle with the inputs currently driven; called at posedge+1.
    task automatic tick();
        int r, g, b, v, idx;
        #1;
        chk("ready", oWr_Ready, (!iRST && !iFrame_Start) ? 1 : 0);
        model_pixel(int'(iVGA_X), int'(iVGA_Y), r, g, b, v, idx);
        if (iRST) begin
            for (int i = 0; i < 16; i++) begin se[i] = 0; ae[i] = 0; end
            {o_r, o_g, o_b, o_v, o_i} = '0;
            {p1_r, p1_g, p1_b, p1_v, p1_i} = '0;
        end else begin
            o_r = p1_r; o_g = p1_g; o_b = p1_b; o_v = p1_v; o_i = p1_i;
            p1_r = r; p1_g = g; p1_b = b; p1_v = v; p1_i = idx;
            if (iFrame_Start) begin
                for (int i = 0; i < 16; i++) begin
                    ax[i] = sx[i]; ay[i] = sy[i]; aw[i] = sw[i]; ah[i] = sh[i];
                    at[i] = st[i]; ae[i] = se[i];
                end
            end else if (iWr_Valid) begin
                sx[iWr_Idx] = int'(iWr_X); sy[iWr_Idx] = int'(iWr_Y);
                sw[iWr_Idx] = int'(iWr_W); sh[iWr_Idx] = int'(iWr_H);
                st[iWr_Idx] = int'(iWr_Type); se[iWr_Idx] = iWr_En;
            end
        end
        @(posedge clk);
        #1;
        chk("red", oRed, o_r);
        chk("green", oGreen, o_g);
        chk("blue", oBlue, o_b);
        chk("hit_valid", oHit_Valid, o_v);
        chk("hit_idx", oHit_Idx, o_i);
    endtask

    task automatic wr(input int idx, input int x, input int y, input int w, input int h,
                      input int kind, input bit en);
        iWr_Idx = 4'(idx); iWr_X = 10'(x); iWr_Y = 10'(y); iWr_W = 10'(w); iWr_H = 10'(h);
        iWr_Type = 10'(kind); iWr_En = en; iWr_Valid = 1'b1;
        tick();
        iWr_Valid = 1'b0;
    endtask

    task automatic frame();
        iFrame_Start = 1'b1;
        tick();
        iFrame_Start = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        iVGA_X = 10'(x); iVGA_Y = 10'(y);
        tick();
    endtask

    function automatic int rand_coord();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 63));
    endfunction

    initial begin
        int kinds[6] = '{101, 102, 201, 202, 302, 77};
        for (int i = 0; i < 16; i++) begin
            sx[i] = 0; sy[i] = 0; sw[i] = 0; sh[i] = 0; st[i] = 0; se[i] = 0;
            ax[i] = 0; ay[i] = 0; aw[i] = 0; ah[i] = 0; at[i] = 0; ae[i] = 0;
        end
        iRST = 1'b1; iFrame_Start = 1'b0; iWr_Valid = 1'b0; iWr_En = 1'b0;
        iVGA_X = '0; iVGA_Y = '0; iWr_X = '0; iWr_Y = '0; iWr_W = '0; iWr_H = '0;
        iWr_Type = '0; iWr_Idx = '0;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_red", oRed, 0);
        chk("rst_hit_valid", oHit_Valid, 0);
        iRST = 1'b0;

        // Single object, hit and the exclusive right edge.
        wr(0, 100, 100, 10, 10, 101, 1'b1);
        frame();
        pix(100, 100);
        pix(110, 100);
        chk("s0_green", oGreen, 255);
        chk("s0_idx", oHit_Idx, 0);
        chk("s0_valid", oHit_Valid, 1);
        pix(0, 0);
        chk("s0_edge_valid", oHit_Valid, 0);
        chk("s0_edge_green", oGreen, 0);

        // Overlap: lower index wins.
        wr(3, 40, 40, 20, 20, 201, 1'b1);
        wr(1, 45, 45, 10, 10, 202, 1'b1);
        frame();
        pix(50, 50);
        pix(0, 0);
        chk("prio_idx", oHit_Idx, 1);
        chk("prio_red", oRed, 0);
        chk("prio_blue", oBlue, 255);

        // Shadow rewrite only takes effect at the next frame start.
        wr(0, 300, 100, 10, 10, 101, 1'b1);
        pix(100, 100);
        pix(0, 0);
        chk("dbuf_old_green", oGreen, 255);
        frame();
        pix(100, 100);
        pix(0, 0);
        chk("dbuf_new_valid", oHit_Valid, 0);
        chk("dbuf_new_green", oGreen, 0);

        // Write held across a frame start is accepted the following cycle.
        iWr_Idx = 4'd5; iWr_X = 10'd200; iWr_Y = 10'd200; iWr_W = 10'd4; iWr_H = 10'd4;
        iWr_Type = 10'd302; iWr_En = 1'b1; iWr_Valid = 1'b1; iFrame_Start = 1'b1;
        #1;
        chk("fs_ready_low", oWr_Ready, 0);
        tick();
        iFrame_Start = 1'b0;
        #1;
        chk("post_fs_ready", oWr_Ready, 1);
        tick();
        iWr_Valid = 1'b0;
        frame();
        pix(201, 201);
        pix(0, 0);
        chk("late_wr_idx", oHit_Idx, 5);
        chk("late_wr_red", oRed, 204);

        // Right-edge clipping near the top coordinate.
        wr(2, 1020, 0, 10, 5, 302, 1'b1);
        frame();
        pix(1023, 0);
        pix(500, 500);
        chk("clip_valid", oHit_Valid, 1);
        chk("clip_idx", oHit_Idx, 2);
        for (int x = 0; x < 10; x++) pix(x, 0);
        pix(500, 500);
        chk("nowrap_valid", oHit_Valid, 0);

        // Reset mid-frame clears outputs and tables.
        pix(50, 50);
        iRST = 1'b1;
        pix(50, 50);
        chk("midrst_valid", oHit_Valid, 0);
        chk("midrst_blue", oBlue, 0);
        iRST = 1'b0;
        frame();
        pix(50, 50);
        pix(1023, 0);
        chk("postrst_a_valid", oHit_Valid, 0);
        pix(0, 0);
        chk("postrst_b_valid", oHit_Valid, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int k;
            k = int'($urandom_range(0, 199));
            iRST = (k == 0);
            iFrame_Start = (k >= 1 && k < 9);
            iWr_Valid = ($urandom_range(0, 3) == 0);
            iWr_Idx = 4'($urandom_range(0, 15));
            iWr_X = 10'(rand_coord());
            iWr_Y = 10'(rand_coord());
            iWr_W = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 24));
            iWr_H = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 24));
            iWr_Type = 10'(kinds[$urandom_range(0, 5)]);
            iWr_En = ($urandom_range(0, 4) != 0);
            iVGA_X = 10'(rand_coord());
            iVGA_Y = 10'(rand_coord());
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
